// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and default constants for the data-memory arbiter.
//   DMEM_ADDR_W / DMEM_DATA_W : default memory word address / data widths
//   DMEM_WAIT_LIMIT           : default anti-starvation threshold
//   WAIT_W / WAIT_MAX         : width and saturation value of the wait counter
//   owner_e                   : which requester issued a pending read
//   mem_req_t                 : one memory command at the default widths
package dmem_pkg;

  localparam int DMEM_ADDR_W     = 9;
  localparam int DMEM_DATA_W     = 32;
  localparam int DMEM_WAIT_LIMIT = 4;

  localparam int                WAIT_W   = 4;
  localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

  typedef struct packed {
    logic                   we;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/dmem_starve_ctr.sv
// dmem_starve_ctr: counts consecutive cycles the debug master requested but
// was denied, saturating at WAIT_MAX, and flags when the count has reached
// WAIT_LIMIT so the arbiter lets debug win the next arbitration.
//   clk, reset : clock, synchronous active-high reset
//   dbg_req    : debug master is requesting this cycle
//   dbg_gnt    : debug master was granted this cycle
//   wait_cnt   : current denied-cycle count
//   starved    : wait_cnt >= WAIT_LIMIT
module dmem_starve_ctr
  import dmem_pkg::*;
#(
  parameter int WAIT_LIMIT = DMEM_WAIT_LIMIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dbg_req,
  input  logic              dbg_gnt,
  output logic [WAIT_W-1:0] wait_cnt,
  output logic              starved
);

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (!dbg_req || dbg_gnt) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_MAX) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign starved = (wait_cnt >= WAIT_W'(WAIT_LIMIT));

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the core
// load/store path and a debug/loader master. The core has priority, but a
// debug master denied WAIT_LIMIT consecutive cycles wins the next slot.
// Memory reads have one cycle of latency; a pending-read register remembers
// who issued the read so the data is returned only to that requester.
//   clk, reset          : clock, synchronous active-high reset
//   cpu_* / dbg_*       : requester ports (req/we/addr/wdata in,
//                         gnt/rvalid/rdata out, cpu_stall for the core)
//   mem_*               : memory command (wr/rd/addr/wr_data) and read data
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DATA_W     = DMEM_DATA_W,
  parameter int ADDR_W     = DMEM_ADDR_W,
  parameter int WAIT_LIMIT = DMEM_WAIT_LIMIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data
);

  // Same layout as mem_req_t, but sized by this instance's parameters.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  req_t              cpu_cmd;
  req_t              dbg_cmd;
  req_t              win_cmd;
  logic              cpu_win;
  logic              dbg_win;
  logic              any_win;
  logic              dbg_starved;
  logic [WAIT_W-1:0] wait_cnt;
  logic              pend_valid;
  owner_e            pend_owner;

  assign cpu_cmd = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
  assign dbg_cmd = '{we: dbg_we, addr: dbg_addr, wdata: dbg_wdata};

  dmem_starve_ctr #(
    .WAIT_LIMIT(WAIT_LIMIT)
  ) u_starve (
    .clk     (clk),
    .reset   (reset),
    .dbg_req (dbg_req),
    .dbg_gnt (dbg_win),
    .wait_cnt(wait_cnt),
    .starved (dbg_starved)
  );

  // Debug wins when the core is idle or debug has been starved long enough.
  // Grants are held off while reset is asserted so the memory sees nothing.
  always_comb begin
    dbg_win = ~reset & dbg_req & (dbg_starved | ~cpu_req);
    cpu_win = ~reset & cpu_req & ~dbg_win;
    win_cmd = '0;
    if (dbg_win) begin
      win_cmd = dbg_cmd;
    end else if (cpu_win) begin
      win_cmd = cpu_cmd;
    end
  end

  assign any_win     = cpu_win | dbg_win;
  assign cpu_gnt     = cpu_win;
  assign dbg_gnt     = dbg_win;
  assign cpu_stall   = cpu_req & ~cpu_win;
  assign mem_wr      = any_win & win_cmd.we;
  assign mem_rd      = any_win & ~win_cmd.we;
  assign mem_addr    = win_cmd.addr;
  assign mem_wr_data = win_cmd.wdata;

  // Tag every granted read with its owner; the tag lives for exactly the
  // cycle in which the memory presents the data.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_owner <= OWN_CPU;
    end else begin
      pend_valid <= mem_rd;
      if (mem_rd) begin
        pend_owner <= dbg_win ? OWN_DBG : OWN_CPU;
      end
    end
  end

  // Reset in the return cycle suppresses the response even though the
  // pending register only clears at the end of that cycle.
  assign cpu_rvalid = pend_valid & ~reset & (pend_owner == OWN_CPU);
  assign dbg_rvalid = pend_valid & ~reset & (pend_owner == OWN_DBG);
  assign cpu_rdata  = cpu_rvalid ? mem_rd_data : '0;
  assign dbg_rdata  = dbg_rvalid ? mem_rd_data : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: drives directed and randomized traffic into dmem_arbiter,
// plays the role of the 1-cycle-latency data memory, and compares every
// output each cycle against a behavioural model of the arbitration rules.
module tb_dmem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [8:0]  cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_gnt;
  logic        cpu_stall;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        dbg_req = 1'b0;
  logic        dbg_we = 1'b0;
  logic [8:0]  dbg_addr = '0;
  logic [31:0] dbg_wdata = '0;
  logic        dbg_gnt;
  logic        dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic        mem_wr;
  logic        mem_rd;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data = '0;

  int checks = 0;
  int failures = 0;

  // Memory instance seen by the DUT.
  logic [31:0] ram [512];

  // Behavioural model state.
  logic [31:0] model_mem [512];
  int          m_wait = 0;
  bit          m_pv = 1'b0;
  bit          m_po_dbg = 1'b0;
  logic [31:0] m_pdata = '0;
  bit          exp_cg;
  bit          exp_dg;

  dmem_arbiter #(
    .DATA_W    (32),
    .ADDR_W    (9),
    .WAIT_LIMIT(LIMIT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_stall  (cpu_stall),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_gnt    (dbg_gnt),
    .dbg_rvalid (dbg_rvalid),
    .dbg_rdata  (dbg_rdata),
    .mem_wr     (mem_wr),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wr) ram[mem_addr] <= mem_wr_data;
    if (mem_rd) mem_rd_data <= ram[mem_addr];
  end

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of inputs, compares all outputs with the model, then
  // advances the model to the next cycle.
  task automatic applyStimulus(input logic rst,
                               input logic c_req, input logic c_we,
                               input logic [8:0] c_addr, input logic [31:0] c_wd,
                               input logic d_req, input logic d_we,
                               input logic [8:0] d_addr, input logic [31:0] d_wd);
    bit          e_wr, e_rd, e_cv, e_dv;
    logic [8:0]  e_addr;
    logic [31:0] e_wd;
    @(negedge clk);
    reset = rst;
    cpu_req = c_req; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wd;
    dbg_req = d_req; dbg_we = d_we; dbg_addr = d_addr; dbg_wdata = d_wd;
    #1;
    exp_dg = !rst && d_req && ((m_wait >= LIMIT) || !c_req);
    exp_cg = !rst && c_req && !exp_dg;
    e_wr = 1'b0; e_rd = 1'b0; e_addr = '0; e_wd = '0;
    if (exp_dg) begin
      e_wr = d_we; e_rd = !d_we; e_addr = d_addr; e_wd = d_wd;
    end else if (exp_cg) begin
      e_wr = c_we; e_rd = !c_we; e_addr = c_addr; e_wd = c_wd;
    end
    e_cv = !rst && m_pv && !m_po_dbg;
    e_dv = !rst && m_pv && m_po_dbg;

    checkOutput("cpu_gnt", 32'(cpu_gnt), 32'(exp_cg));
    checkOutput("dbg_gnt", 32'(dbg_gnt), 32'(exp_dg));
    checkOutput("cpu_stall", 32'(cpu_stall), 32'(c_req && !exp_cg));
    checkOutput("mem_wr", 32'(mem_wr), 32'(e_wr));
    checkOutput("mem_rd", 32'(mem_rd), 32'(e_rd));
    checkOutput("mem_addr", 32'(mem_addr), 32'(e_addr));
    checkOutput("mem_wr_data", mem_wr_data, e_wd);
    checkOutput("cpu_rvalid", 32'(cpu_rvalid), 32'(e_cv));
    checkOutput("cpu_rdata", cpu_rdata, e_cv ? m_pdata : 32'h0);
    checkOutput("dbg_rvalid", 32'(dbg_rvalid), 32'(e_dv));
    checkOutput("dbg_rdata", dbg_rdata, e_dv ? m_pdata : 32'h0);
    checkOutput("wait_cnt", 32'(dut.wait_cnt), 32'(m_wait));

    if (rst) begin
      m_wait = 0;
      m_pv = 1'b0;
    end else begin
      if (d_req && !exp_dg) m_wait = (m_wait >= 15) ? 15 : m_wait + 1;
      else m_wait = 0;
      m_pv = e_rd;
      if (e_rd) begin
        m_po_dbg = exp_dg;
        m_pdata = model_mem[e_addr];
      end
      if (e_wr) model_mem[e_addr] = e_wd;
    end
  endtask

  task automatic idle(input logic rst);
    applyStimulus(rst, 1'b0, 1'b0, 9'h0, 32'h0, 1'b0, 1'b0, 9'h0, 32'h0);
  endtask

  logic        c_r, c_w, d_r, d_w, rst_r;
  logic [8:0]  c_a, d_a;
  logic [31:0] c_d, d_d;
  bit          c_hold, d_hold;

  initial begin
    for (int i = 0; i < 512; i++) begin
      ram[i] = init_word(i);
      model_mem[i] = init_word(i);
    end
    ram[9'h010] = 32'hDEAD_BEEF;
    model_mem[9'h010] = 32'hDEAD_BEEF;

    $display("[TB] reset and idle");
    idle(1'b1);
    idle(1'b1);
    for (int i = 0; i < 10; i++) begin
      idle(1'b0);
      checkOutput("idle_mem_rd", 32'(mem_rd), 32'h0);
      checkOutput("idle_cpu_gnt", 32'(cpu_gnt), 32'h0);
    end

    $display("[TB] core-only read");
    applyStimulus(1'b0, 1'b1, 1'b0, 9'h010, 32'h0, 1'b0, 1'b0, 9'h0, 32'h0);
    checkOutput("rd_gnt", 32'(cpu_gnt), 32'h1);
    checkOutput("rd_mem_rd", 32'(mem_rd), 32'h1);
    checkOutput("rd_mem_addr", 32'(mem_addr), 32'h010);
    idle(1'b0);
    checkOutput("rd_rvalid", 32'(cpu_rvalid), 32'h1);
    checkOutput("rd_rdata", cpu_rdata, 32'hDEAD_BEEF);
    checkOutput("rd_dbg_rvalid", 32'(dbg_rvalid), 32'h0);

    $display("[TB] contention with starvation");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 9'h020, 32'h0, 1'b1, 1'b0, 9'h030, 32'h0);
      checkOutput("starve_cpu_gnt", 32'(cpu_gnt), (i == 4) ? 32'h0 : 32'h1);
      checkOutput("starve_dbg_gnt", 32'(dbg_gnt), (i == 4) ? 32'h1 : 32'h0);
      checkOutput("starve_cpu_stall", 32'(cpu_stall), (i == 4) ? 32'h1 : 32'h0);
      checkOutput("starve_wait", 32'(dut.wait_cnt), (i == 5) ? 32'h0 : 32'(i));
    end

    $display("[TB] interleaved reads");
    applyStimulus(1'b0, 1'b1, 1'b0, 9'h001, 32'h0, 1'b0, 1'b0, 9'h0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 9'h0, 32'h0, 1'b1, 1'b0, 9'h1FF, 32'h0);
    checkOutput("il_cpu_rvalid", 32'(cpu_rvalid), 32'h1);
    checkOutput("il_dbg_rvalid1", 32'(dbg_rvalid), 32'h0);
    checkOutput("il_cpu_rdata", cpu_rdata, init_word(1));
    idle(1'b0);
    checkOutput("il_dbg_rvalid2", 32'(dbg_rvalid), 32'h1);
    checkOutput("il_cpu_rvalid2", 32'(cpu_rvalid), 32'h0);
    checkOutput("il_dbg_rdata", dbg_rdata, init_word(511));

    $display("[TB] debug write while core idle");
    applyStimulus(1'b0, 1'b0, 1'b0, 9'h0, 32'h0, 1'b1, 1'b1, 9'h0A0, 32'h1234_5678);
    checkOutput("dw_mem_wr", 32'(mem_wr), 32'h1);
    checkOutput("dw_wr_data", mem_wr_data, 32'h1234_5678);
    checkOutput("dw_dbg_gnt", 32'(dbg_gnt), 32'h1);
    applyStimulus(1'b0, 1'b1, 1'b0, 9'h0A0, 32'h0, 1'b0, 1'b0, 9'h0, 32'h0);
    checkOutput("dw_no_rvalid", 32'(cpu_rvalid | dbg_rvalid), 32'h0);
    idle(1'b0);
    checkOutput("dw_readback", cpu_rdata, 32'h1234_5678);

    $display("[TB] reset mid-read");
    applyStimulus(1'b0, 1'b1, 1'b0, 9'h010, 32'h0, 1'b1, 1'b0, 9'h005, 32'h0);
    idle(1'b1);
    checkOutput("rst_cpu_rvalid", 32'(cpu_rvalid), 32'h0);
    idle(1'b0);
    checkOutput("rst_wait", 32'(dut.wait_cnt), 32'h0);
    checkOutput("rst_outputs", 32'({cpu_gnt, cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid, mem_wr, mem_rd}), 32'h0);

    $display("[TB] randomized traffic");
    c_hold = 1'b0; d_hold = 1'b0;
    c_r = 1'b0; c_w = 1'b0; c_a = '0; c_d = '0;
    d_r = 1'b0; d_w = 1'b0; d_a = '0; d_d = '0;
    for (int n = 0; n < 3000; n++) begin
      rst_r = ($urandom_range(0, 99) == 0);
      if (rst_r) begin
        c_hold = 1'b0; d_hold = 1'b0; c_r = 1'b0; d_r = 1'b0;
      end else begin
        if (!c_hold) begin
          c_r = ($urandom_range(0, 99) < 60);
          c_w = 1'($urandom_range(0, 1));
          c_a = 9'($urandom_range(0, 31));
          c_d = $urandom;
        end
        if (!d_hold) begin
          d_r = ($urandom_range(0, 99) < 40);
          d_w = 1'($urandom_range(0, 1));
          d_a = 9'($urandom_range(0, 31));
          d_d = $urandom;
        end
      end
      applyStimulus(rst_r, c_r, c_w, c_a, c_d, d_r, d_w, d_a, d_d);
      c_hold = c_r && !exp_cg;
      d_hold = d_r && !exp_dg;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
